// File: rtl/receptor_serie_paridad.sv
// Serial frame receiver: start / data LSB first / parity / stop.
// Recomputes XOR parity and flags parity and framing faults.
module receptor_serie_paridad #(
  parameter int ANCHO         = 8,
  parameter int SOBREMUESTREO = 16,
  parameter int PARIDAD_IMPAR = 0
) (
  input  logic             Reloj,
  input  logic             Reset_n,
  input  logic             Tick,
  input  logic             EntradaSerie,
  output logic [ANCHO-1:0] Dato,
  output logic             DatoValido,
  output logic             ErrorParidad,
  output logic             ErrorTrama,
  output logic             Ocupado
);

  localparam int CW = $clog2(SOBREMUESTREO);
  localparam int IW = $clog2(ANCHO + 1);

  localparam logic [CW-1:0] MITAD  = CW'(SOBREMUESTREO / 2 - 1);
  localparam logic [CW-1:0] ULTIMO = CW'(SOBREMUESTREO - 1);
  localparam logic [IW-1:0] FIN    = IW'(ANCHO - 1);
  localparam logic          PAR0   = (PARIDAD_IMPAR != 0);

  typedef enum logic [2:0] {
    REPOSO,
    INICIO,
    DATOS,
    PARIDAD,
    PARADA,
    ESPERA_ALTO
  } estado_t;

  estado_t          estado;
  logic             s1;
  logic             s;
  logic [CW-1:0]    cnt;
  logic [IW-1:0]    idx;
  logic [ANCHO-1:0] hold;
  logic             par;

  // Synchroniser, frame FSM and registered outputs in one process
  always_ff @(posedge Reloj or negedge Reset_n) begin
    if (!Reset_n) begin
      s1           <= 1'b1;
      s            <= 1'b1;
      estado       <= REPOSO;
      cnt          <= '0;
      idx          <= '0;
      hold         <= '0;
      par          <= 1'b0;
      Dato         <= '0;
      DatoValido   <= 1'b0;
      ErrorParidad <= 1'b0;
      ErrorTrama   <= 1'b0;
      Ocupado      <= 1'b0;
    end else begin
      s1         <= EntradaSerie;
      s          <= s1;
      DatoValido <= 1'b0;
      ErrorTrama <= 1'b0;
      if (Tick) begin
        unique case (estado)
          REPOSO: begin
            if (!s) begin
              estado  <= INICIO;
              cnt     <= '0;
              Ocupado <= 1'b1;
            end
          end
          INICIO: begin
            if (cnt == MITAD) begin
              cnt <= '0;
              if (!s) begin
                estado <= DATOS;
                idx    <= '0;
                par    <= PAR0;
              end else begin
                estado  <= REPOSO;
                Ocupado <= 1'b0;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          DATOS: begin
            if (cnt == ULTIMO) begin
              cnt  <= '0;
              hold <= (hold >> 1) | (ANCHO'(s) << (ANCHO - 1));
              par  <= par ^ s;
              if (idx == FIN) begin
                estado <= PARIDAD;
              end else begin
                idx <= idx + 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          PARIDAD: begin
            if (cnt == ULTIMO) begin
              cnt    <= '0;
              par    <= par ^ s;
              estado <= PARADA;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          PARADA: begin
            if (cnt == ULTIMO) begin
              cnt <= '0;
              if (s) begin
                Dato         <= hold;
                ErrorParidad <= par;
                DatoValido   <= 1'b1;
                estado       <= REPOSO;
                Ocupado      <= 1'b0;
              end else begin
                ErrorTrama <= 1'b1;
                estado     <= ESPERA_ALTO;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ESPERA_ALTO: begin
            if (s) begin
              estado  <= REPOSO;
              Ocupado <= 1'b0;
            end
          end
          default: begin
            estado  <= REPOSO;
            Ocupado <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_receptor_serie_paridad.sv
// Directed bench for receptor_serie_paridad.
// Frames driven bit by bit, pulses counted by a monitor.
module tb_receptor_serie_paridad;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic       line;
  logic [7:0] dato;
  logic       dv;
  logic       ep;
  logic       et;
  logic       ocup;

  int n_run;
  int n_fail;
  int n_dv;
  int n_et;
  int n_both;
  int cyc;
  int t_last;
  int t_prev;

  receptor_serie_paridad #(
    .ANCHO(8),
    .SOBREMUESTREO(16),
    .PARIDAD_IMPAR(0)
  ) dut (
    .Reloj(clk),
    .Reset_n(rst_n),
    .Tick(tick),
    .EntradaSerie(line),
    .Dato(dato),
    .DatoValido(dv),
    .ErrorParidad(ep),
    .ErrorTrama(et),
    .Ocupado(ocup)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitor, sampled away from the active edge
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (dv) begin
      n_dv   = n_dv + 1;
      t_prev = t_last;
      t_last = cyc;
    end
    if (et) n_et = n_et + 1;
    if (dv && et) n_both = n_both + 1;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_run = n_run + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    n_dv   = 0;
    n_et   = 0;
    t_last = 0;
    t_prev = 0;
  endtask

  task automatic idle(input int n);
    line = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    line = b;
    repeat (16) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d,
                            input logic p,
                            input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(stop);
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    n_both = 0;
    cyc    = 0;
    clr();
    tick  = 1'b1;
    line  = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_dato", 32'(dato), 32'h0);
    check("rst_dv", 32'(dv), 32'h0);
    check("rst_ep", 32'(ep), 32'h0);
    check("rst_et", 32'(et), 32'h0);
    check("rst_ocup", 32'(ocup), 32'h0);
    rst_n = 1'b1;
    idle(20);

    // Good frame
    clr();
    send_frame(8'hA5, 1'b0, 1'b1);
    idle(20);
    check("a5_nv", 32'(n_dv), 32'd1);
    check("a5_dato", 32'(dato), 32'hA5);
    check("a5_ep", 32'(ep), 32'h0);
    check("a5_net", 32'(n_et), 32'd0);

    // Bad parity then good parity
    clr();
    send_frame(8'h07, 1'b0, 1'b1);
    idle(20);
    check("07_nv", 32'(n_dv), 32'd1);
    check("07_dato", 32'(dato), 32'h07);
    check("07_ep", 32'(ep), 32'h1);
    clr();
    send_frame(8'h03, 1'b0, 1'b1);
    idle(20);
    check("03_dato", 32'(dato), 32'h03);
    check("03_ep", 32'(ep), 32'h0);

    // Start glitch
    clr();
    line = 1'b0;
    repeat (5) @(negedge clk);
    line = 1'b1;
    for (int i = 0; i < 10 && ocup; i++) @(negedge clk);
    check("gl_ocup", 32'(ocup), 32'h0);
    idle(200);
    check("gl_nv", 32'(n_dv), 32'd0);
    check("gl_net", 32'(n_et), 32'd0);

    // Framing error with break
    clr();
    send_frame(8'h3C, 1'b0, 1'b0);
    line = 1'b0;
    repeat (100) @(negedge clk);
    idle(40);
    check("fe_net", 32'(n_et), 32'd1);
    check("fe_nv", 32'(n_dv), 32'd0);
    check("fe_dato", 32'(dato), 32'h03);
    clr();
    send_frame(8'h55, 1'b0, 1'b1);
    idle(20);
    check("55_nv", 32'(n_dv), 32'd1);
    check("55_dato", 32'(dato), 32'h55);
    check("55_ep", 32'(ep), 32'h0);

    // Reset during data bit 4
    clr();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    line = 1'b1;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("ab_dato", 32'(dato), 32'h0);
    check("ab_ocup", 32'(ocup), 32'h0);
    rst_n = 1'b1;
    idle(200);
    check("ab_nv", 32'(n_dv), 32'd0);
    check("ab_net", 32'(n_et), 32'd0);
    send_frame(8'h81, 1'b0, 1'b1);
    idle(20);
    check("81_nv", 32'(n_dv), 32'd1);
    check("81_dato", 32'(dato), 32'h81);
    check("81_ep", 32'(ep), 32'h0);

    // Back-to-back frames
    clr();
    send_frame(8'h12, 1'b0, 1'b1);
    send_frame(8'h34, 1'b1, 1'b1);
    idle(30);
    check("bb_nv", 32'(n_dv), 32'd2);
    check("bb_dato", 32'(dato), 32'h34);
    check("bb_ep", 32'(ep), 32'h0);
    check("bb_gap", 32'(t_last - t_prev), 32'd176);

    check("dv_et_excl", 32'(n_both), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/receptor_serie_paridad.md
Name: receptor_serie_paridad

Overview:
Serial frame receiver with parity check. It is the receiving end of the XOR parity path: it deserialises an asynchronous line of the form start / data (LSB first) / parity / stop. It recomputes the bitwise XOR parity over the data and flags any mismatch or framing fault. It sits between the line input pin and the parallel consumer logic, and is clocked by the system clock with an external oversampling strobe.

Parameters:
ANCHO, 8, number of data bits per frame (1..16)
SOBREMUESTREO, 16, Tick strobes per bit period (even, >=4)
PARIDAD_IMPAR, 0, 0 = even parity (XOR of data bits plus parity bit = 0); 1 = odd parity (XOR = 1)

Ports:
Reloj  input  1  system clock, all logic on rising edge
Reset_n  input  1  asynchronous active-low reset
Tick  input  1  one-cycle oversampling strobe, SOBREMUESTREO per bit period
EntradaSerie  input  1  asynchronous serial line, idle high
Dato  output  ANCHO  last received data word
DatoValido  output  1  one-cycle pulse: new frame with valid stop bit
ErrorParidad  output  1  parity result of the frame flagged by DatoValido; held until next DatoValido
ErrorTrama  output  1  one-cycle pulse: stop bit sampled low
Ocupado  output  1  high while a frame is in progress (any state except REPOSO)

Behaviour:
- Reset (async, Reset_n=0):
  - Outputs: Dato=0, DatoValido=0, ErrorParidad=0, ErrorTrama=0, Ocupado=0.
  - State=REPOSO; counters cleared; synchroniser flops preset to 1.
- Reset asserted mid-frame aborts the frame with no pulses. After release, reception restarts from REPOSO.
- EntradaSerie passes through a 2-flop synchroniser. All decisions use the synchronised value `s`.
- Counters only advance on cycles with Tick=1. Without Tick the state is frozen.
- State REPOSO:
  - On a Tick with s=0 -> INICIO, tick counter=0.
- State INICIO:
  - Count Tick up to SOBREMUESTREO/2-1 (mid-bit).
  - If s=0 at that tick -> DATOS, bit index=0, running parity=PARIDAD_IMPAR.
  - If s=1 (glitch) -> REPOSO, no outputs.
- State DATOS:
  - Sample s every SOBREMUESTREO ticks and shift into a holding register, LSB first.
  - Running parity ^= s.
  - After sample ANCHO-1 -> PARIDAD.
- State PARIDAD:
  - Sample s after SOBREMUESTREO ticks; running parity ^= s -> PARADA.
- State PARADA, sample after SOBREMUESTREO ticks:
  - s=1: on the next clock edge Dato<=holding register, ErrorParidad<=running parity, DatoValido=1 for exactly one cycle -> REPOSO.
  - s=0: ErrorTrama=1 for one cycle; Dato and ErrorParidad unchanged; DatoValido not asserted -> ESPERA_ALTO.
- State ESPERA_ALTO:
  - Stay until a Tick with s=1 -> REPOSO. A break condition (line held low) therefore produces one ErrorTrama only.
- Latency: DatoValido rises 1 clock after the Tick on which the stop bit is sampled. Input path adds 2 clocks (synchroniser).
- A new start edge is accepted on the first Tick in REPOSO with s=0, so back-to-back frames with a single stop bit are received without loss.
- DatoValido and ErrorTrama are never high in the same cycle.
- Ocupado=1 in INICIO, DATOS, PARIDAD, PARADA and ESPERA_ALTO.

Test Plan:
- Common setup: ANCHO=8, SOBREMUESTREO=16, PARIDAD_IMPAR=0, Tick=1 every cycle (16 clocks per bit).
- Frame 0xA5, parity bit 0, stop 1 -> DatoValido one pulse, Dato=0xA5, ErrorParidad=0, ErrorTrama never asserted.
- Frame 0x07, parity bit 0 (correct bit is 1) -> DatoValido pulse, Dato=0x07, ErrorParidad=1. Follow with 0x03, parity 0 -> ErrorParidad returns to 0.
- Line low for 5 clocks, then high for 200 clocks -> no DatoValido, no ErrorTrama, Ocupado returns to 0 within 10 clocks of the line going high.
- Frame 0x3C, parity 0, stop bit 0, line held low 100 clocks then high -> exactly one ErrorTrama pulse, no DatoValido, Dato keeps its previous value. A following valid frame 0x55 is received correctly.
- Reset_n pulsed low during data bit 4 of a frame, then frame 0x81 (parity 0) sent -> no output from the aborted frame, Dato=0x81, ErrorParidad=0. Separately, two back-to-back frames 0x12 and 0x34 -> two DatoValido pulses 176 clocks apart.
